// File: rtl/scanner_scheduler.sv
// Round-robin scheduler for two scanners sharing one serial link to the command node.
// Define SCHED_PARITY_EN to append an even-parity bit after each completed frame.
module scanner_scheduler #(
  parameter int FRAME_BITS = 64,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       scan_req,
  input  logic [1:0]       scan_clk_out,
  input  logic [1:0]       scan_data_out,
  input  logic             link_ready,
  output logic [1:0]       scan_cmd0,
  output logic [1:0]       scan_cmd1,
  output logic [1:0]       scan_ready_xfer,
  output logic [1:0]       grant,
  output logic             link_valid,
  output logic             link_data,
  output logic [1:0]       ps,
  output logic [CNT_W-1:0] frame_count,
  output logic             xfer_err
);

  // state    | meaning
  // S_IDLE   | no session, scanners idle
  // S_COLLECT| both scanners collecting, waiting for a transfer request
  // S_XFER   | link granted to one scanner, forwarding its bits
  // S_DONE   | one-cycle frame wrap-up, granted scanner in standby
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COLLECT = 2'b01,
    S_XFER    = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  localparam logic [1:0] CMD_IDLE    = 2'b00;
  localparam logic [1:0] CMD_COLLECT = 2'b01;
  localparam logic [1:0] CMD_XFER    = 2'b10;
  localparam logic [1:0] CMD_STANDBY = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       grant_q;
  logic             last_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] to_cnt_q;
  logic             stop_lat_q;
  logic             abort_q;

  logic             strobe_g, data_g, accept, idle_cyc, frame_end, timeout_hit;
  logic             par_busy;
  logic [1:0]       arb_grant;

`ifdef SCHED_PARITY_EN
  logic par_phase_q;
  logic par_acc_q;
  assign par_busy = par_phase_q;
`else
  assign par_busy = 1'b0;
`endif

  always_comb begin
    strobe_g    = |(scan_clk_out & grant_q);
    data_g      = |(scan_data_out & grant_q);
    accept      = (state_q == S_XFER) && !par_busy && strobe_g && link_ready;
    idle_cyc    = (state_q == S_XFER) && !par_busy && !strobe_g && link_ready;
    frame_end   = accept && (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
    timeout_hit = idle_cyc && (to_cnt_q == CNT_W'(TIMEOUT - 1));
    // On a tie the scanner that was not served last wins
    case (scan_req)
      2'b01:   arb_grant = 2'b01;
      2'b10:   arb_grant = 2'b10;
      2'b11:   arb_grant = last_q ? 2'b01 : 2'b10;
      default: arb_grant = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_COLLECT;
      S_COLLECT: begin
        if (stop)                          state_d = S_IDLE;
        else if (link_ready && |scan_req)  state_d = S_XFER;
      end
      S_XFER: begin
        if (par_busy || timeout_hit) state_d = S_DONE;
`ifndef SCHED_PARITY_EN
        else if (frame_end)          state_d = S_DONE;
`endif
      end
      S_DONE:    state_d = (stop_lat_q || stop) ? S_IDLE : S_COLLECT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scan_cmd0       = CMD_IDLE;
    scan_cmd1       = CMD_IDLE;
    scan_ready_xfer = 2'b00;
    case (state_q)
      S_COLLECT: begin
        scan_cmd0 = CMD_COLLECT;
        scan_cmd1 = CMD_COLLECT;
      end
      S_XFER: begin
        scan_cmd0       = grant_q[0] ? CMD_XFER : CMD_COLLECT;
        scan_cmd1       = grant_q[1] ? CMD_XFER : CMD_COLLECT;
        scan_ready_xfer = grant_q & {2{link_ready && !par_busy}};
      end
      S_DONE: begin
        scan_cmd0 = grant_q[0] ? CMD_STANDBY : CMD_COLLECT;
        scan_cmd1 = grant_q[1] ? CMD_STANDBY : CMD_COLLECT;
      end
      default: ;
    endcase
  end

  assign ps    = state_q;
  assign grant = grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stop_lat_q  <= 1'b0;
      abort_q     <= 1'b0;
      link_valid  <= 1'b0;
      link_data   <= 1'b0;
      frame_count <= '0;
      xfer_err    <= 1'b0;
`ifdef SCHED_PARITY_EN
      par_phase_q <= 1'b0;
      par_acc_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      link_valid <= accept;
      link_data  <= accept & data_g;
      case (state_q)
        S_COLLECT: if (state_d == S_XFER) grant_q <= arb_grant;
        S_XFER: begin
          if (stop) stop_lat_q <= 1'b1;
          if (accept) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            to_cnt_q  <= '0;
          end else if (idle_cyc) begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
          if (timeout_hit) begin
            xfer_err <= 1'b1;
            abort_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!abort_q) frame_count <= frame_count + 1'b1;
          last_q     <= grant_q[1];
          grant_q    <= 2'b00;
          bit_cnt_q  <= '0;
          to_cnt_q   <= '0;
          abort_q    <= 1'b0;
          stop_lat_q <= 1'b0;
        end
        default: ;
      endcase
`ifdef SCHED_PARITY_EN
      if (accept)    par_acc_q   <= par_acc_q ^ data_g;
      if (frame_end) par_phase_q <= 1'b1;
      if (par_phase_q) begin
        link_valid  <= 1'b1;
        link_data   <= par_acc_q;
        par_phase_q <= 1'b0;
      end
      if (state_q == S_DONE) par_acc_q <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/scanner_scheduler.md
Name: scanner_scheduler

Overview:
Sequences two scanner units that share one serial transfer link to the command node. It starts and stops collection sessions and issues collect/transfer commands to each scanner. When scanners request transfer, it arbitrates round-robin, grants the link to one scanner and forwards that scanner's serial bitstream. It counts frame bits, detects stalled transfers and keeps frame statistics.

Parameters:
FRAME_BITS, 64, serial bits per transferred frame (8 buffer entries x 8 bits)
TIMEOUT, 255, max consecutive cycles without a bit strobe before a transfer is aborted
CNT_W, 8, width of bit counter, timeout counter and frame counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: begin a collection session
stop  input  1  one-cycle pulse: end the session
scan_req  input  2  bit i high = scanner i buffer full, requests transfer (level)
scan_clk_out  input  2  bit i = one-cycle bit strobe from scanner i, synchronous to clk
scan_data_out  input  2  bit i = serial data from scanner i, valid with its strobe
link_ready  input  1  command node can accept bits
scan_cmd0  output  2  command to scanner 0: 00 idle, 01 collect, 10 transfer, 11 standby
scan_cmd1  output  2  command to scanner 1, same encoding
scan_ready_xfer  output  2  bit i = scanner i may shift out (readyForTransferIn)
grant  output  2  one-hot current link owner, 00 when none
link_valid  output  1  forwarded bit valid
link_data  output  1  forwarded bit
ps  output  2  present state: 00 IDLE, 01 COLLECT, 10 TRANSFER, 11 DONE
frame_count  output  CNT_W  completed (non-aborted) frames, wraps mod 2^CNT_W
xfer_err  output  1  sticky: a transfer was aborted by timeout

Behaviour:
- Reset (rst low, asynchronous): ps=IDLE, both cmds=00, scan_ready_xfer=00, grant=00, link_valid=0, link_data=0, frame_count=0, xfer_err=0. Round-robin pointer last=1, so scanner 0 wins the first tie. Bit and timeout counters are 0.
- Reset mid-transfer aborts immediately. There is no partial-frame recovery.
- IDLE: cmds=00. A start pulse moves to COLLECT on the next edge. A stop pulse in IDLE is ignored.
- COLLECT: both cmds=01. If stop, go to IDLE. Otherwise, if link_ready=1 and scan_req!=00, go to TRANSFER:
  - Grant the single requester.
  - If both request, grant the scanner != last.
  - grant is registered, valid in the first TRANSFER cycle.
  - stop has priority over a simultaneous request.
- TRANSFER: granted scanner cmd=10; other scanner cmd=01 (keeps collecting).
  - scan_ready_xfer[g] = link_ready (combinational back-pressure).
  - Each cycle with scan_clk_out[g]=1 and link_ready=1: link_valid=1 and link_data=scan_data_out[g] on the next edge (1-cycle latency); bit counter +1; timeout counter cleared.
  - Strobes from the non-granted scanner are ignored.
  - link_valid=0 on cycles with no accepted strobe.
  - Cycles with no strobe while link_ready=1: timeout counter +1. While link_ready=0 the timeout counter freezes.
  - Bit counter reaching FRAME_BITS: go to DONE (normal).
  - Timeout counter reaching TIMEOUT: xfer_err=1, go to DONE (abort).
  - stop in TRANSFER is latched; the frame completes first.
- DONE (1 cycle): granted scanner cmd=11, other cmd=01, scan_ready_xfer=00.
  - frame_count+1 only on normal completion.
  - last=g; grant cleared; bit and timeout counters cleared.
  - Next state: IDLE if stop was latched, else COLLECT.
  - A request still held by the just-served scanner loses to a pending request from the other scanner.
- Counters saturate never; frame_count wraps 2^CNT_W-1 -> 0.
- xfer_err clears only on reset.

Optional Feature:
SCHED_PARITY_EN:
- Defined: after the FRAME_BITS-th accepted bit, TRANSFER holds one extra cycle (ps stays 10) and emits link_valid=1 with link_data = even parity (XOR) of all forwarded frame bits. DONE follows. A timeout abort emits no parity bit.
- Undefined: no parity logic; DONE follows the last frame bit directly.

Test Plan:
1. Reset, start, scan_req=01, link_ready=1, scanner 0 strobes 64 bits -> grant=01, scan_cmd0=10, scan_cmd1=01, 64 link_valid pulses each 1 cycle after its strobe, DONE one cycle with scan_cmd0=11, frame_count=1, ps returns 01.
2. scan_req=11 in COLLECT after reset -> grant=01 first. After its frame, with scan_req still 11 -> grant=10. Then grant=01 again: alternation.
3. During transfer, link_ready=0 for 20 cycles -> scan_ready_xfer=00, no link_valid, timeout counter frozen, no abort. Resume -> frame completes, frame_count increments.
4. Granted scanner stops strobing after 10 bits -> abort after 255 idle cycles, xfer_err=1, frame_count unchanged, ps 10->11->01.
5. stop pulsed mid-transfer -> frame finishes, DONE, then IDLE with both cmds=00. stop together with a request in COLLECT -> IDLE, no grant.
6. rst low mid-transfer at bit 30 -> all outputs immediately at reset values. With SCHED_PARITY_EN, a frame of 0xA5 repeated 8 times -> parity bit 0 emitted in the 65th valid cycle.
